dn_pwl: RTL

8-lane piecewise-linear compressor. It maps signed 8-bit samples to 6-bit sign/segment codes and is the encode-side counterpart of the `up_pwl` expander. It sits on the testbench/datapath boundary wherever 8-bit FFT-domain samples must be requantised onto the 6-bit lane format. Data moves through a 2-stage, valid/ready pipeline with per-lane clip flags and an optional clip-event counter.

---
 rtl/dn_pwl_pkg.sv | 54 +++++
 rtl/dn_pwl_unit.sv | 53 +++++
 rtl/dn_pwl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dn_pwl_pkg.sv
// dn_pwl shared widths, segment table and encode helper.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package dn_pwl_pkg;

    localparam int SAMPLE_W = 8;
    localparam int CODE_W   = 6;
    localparam int LANES    = 8;
    localparam int MAG_W    = SAMPLE_W + 1;
    localparam int SEG_W    = CODE_W - 1;

    localparam logic [MAG_W-1:0] BRK1 = MAG_W'(16);
    localparam logic [MAG_W-1:0] BRK2 = MAG_W'(48);
    localparam logic [MAG_W-1:0] BRK3 = MAG_W'(112);

    localparam logic [SEG_W-1:0] BASE0   = SEG_W'(0);
    localparam logic [SEG_W-1:0] BASE1   = SEG_W'(16);
    localparam logic [SEG_W-1:0] BASE2   = SEG_W'(24);
    localparam logic [SEG_W-1:0] SEG_MAX = SEG_W'(31);

    localparam int SHIFT0 = 0;
    localparam int SHIFT1 = 2;
    localparam int SHIFT2 = 3;

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
        logic             clip;
    } s1_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              clip;
    } s2_t;

    function automatic logic [SEG_W-1:0] seg_encode(input logic [MAG_W-1:0] m);
        logic [MAG_W-1:0] off;
        logic [SEG_W-1:0] seg;
        off = '0;
        seg = SEG_MAX;
        if (m < BRK1) begin
            off = m >> SHIFT0;
            seg = BASE0 + off[SEG_W-1:0];
        end else if (m < BRK2) begin
            off = (m - BRK1) >> SHIFT1;
            seg = BASE1 + off[SEG_W-1:0];
        end else if (m < BRK3) begin
            off = (m - BRK2) >> SHIFT2;
            seg = BASE2 + off[SEG_W-1:0];
        end
        return seg;
    endfunction

endpackage

// File: rtl/dn_pwl_unit.sv
// One lane: stage 1 abs/saturate, stage 2 segment encode.
// Latency: 2 enabled edges from x_i to code_o.
// Backpressure: each stage holds while its enable from the top is low.
module dn_pwl_unit
    import dn_pwl_pkg::*;
(
    input  logic                       clk,
    input  logic                       arstb,
    input  logic                       rstb,
    input  logic                       s1_en_i,
    input  logic                       s2_en_i,
    input  logic signed [SAMPLE_W-1:0] x_i,
    output logic        [CODE_W-1:0]   code_o,
    output logic                       clip_o
);

    logic [MAG_W-1:0] sext_w;
    logic [MAG_W-1:0] mag_w;
    s1_t              s1_d, s1_q;
    s2_t              s2_d, s2_q;

    // 9-bit magnitude so that -128 maps to +128 rather than wrapping
    assign sext_w = {x_i[SAMPLE_W-1], x_i};
    assign mag_w  = x_i[SAMPLE_W-1] ? (MAG_W'(0) - sext_w) : sext_w;

    always_comb begin
        s1_d.sign = x_i[SAMPLE_W-1];
        s1_d.mag  = mag_w;
        s1_d.clip = (mag_w >= BRK3);
    end

    always_comb begin
        s2_d.code = {s1_q.sign, seg_encode(s1_q.mag)};
        s2_d.clip = s1_q.clip;
    end

    always_ff @(posedge clk or negedge arstb) begin
        if (!arstb) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (!rstb) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (s1_en_i) s1_q <= s1_d;
            if (s2_en_i) s2_q <= s2_d;
        end
    end

    assign code_o = s2_q.code;
    assign clip_o = s2_q.clip;

endmodule

// File: rtl/dn_pwl.sv
// 8-lane PWL compressor, signed 8b -> 6b sign/segment code; DN_PWL_CLIP_CNT_EN adds clip counter.
// Latency: 2 cycles, 1 beat/clock when out_ready is high.
// Backpressure: valid/ready, holds 2 beats then drops in_ready; out_ready->in_ready is combinational.
module dn_pwl
    import dn_pwl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       arstb,
    input  logic                       rstb,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] x0_in,
    input  logic signed [SAMPLE_W-1:0] x1_in,
    input  logic signed [SAMPLE_W-1:0] x2_in,
    input  logic signed [SAMPLE_W-1:0] x3_in,
    input  logic signed [SAMPLE_W-1:0] x4_in,
    input  logic signed [SAMPLE_W-1:0] x5_in,
    input  logic signed [SAMPLE_W-1:0] x6_in,
    input  logic signed [SAMPLE_W-1:0] x7_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic        [CODE_W-1:0]   x0,
    output logic        [CODE_W-1:0]   x1,
    output logic        [CODE_W-1:0]   x2,
    output logic        [CODE_W-1:0]   x3,
    output logic        [CODE_W-1:0]   x4,
    output logic        [CODE_W-1:0]   x5,
    output logic        [CODE_W-1:0]   x6,
    output logic        [CODE_W-1:0]   x7,
    output logic        [LANES-1:0]    clip,
    input  logic                       clip_clr,
    output logic        [CNT_W-1:0]    clip_cnt
);

    logic                       s1_vld_q, s1_vld_d;
    logic                       s2_vld_q, s2_vld_d;
    logic                       s1_adv;
    logic                       s1_en;
    logic                       s2_en;
    logic signed [SAMPLE_W-1:0] lane_x    [LANES];
    logic        [CODE_W-1:0]   lane_code [LANES];
    logic        [LANES-1:0]    lane_clip;

    assign s1_adv   = !s2_vld_q || out_ready;
    assign in_ready = !s1_vld_q || s1_adv;
    assign s1_en    = in_valid && in_ready;
    assign s2_en    = s1_vld_q && s1_adv;

    always_comb begin
        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;
        if (in_ready) s1_vld_d = in_valid;
        if (s1_adv)   s2_vld_d = s1_vld_q;
    end

    always_ff @(posedge clk or negedge arstb) begin
        if (!arstb) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else if (!rstb) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
        end
    end

    assign lane_x[0] = x0_in;
    assign lane_x[1] = x1_in;
    assign lane_x[2] = x2_in;
    assign lane_x[3] = x3_in;
    assign lane_x[4] = x4_in;
    assign lane_x[5] = x5_in;
    assign lane_x[6] = x6_in;
    assign lane_x[7] = x7_in;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        dn_pwl_unit u_unit (
            .clk     (clk),
            .arstb   (arstb),
            .rstb    (rstb),
            .s1_en_i (s1_en),
            .s2_en_i (s2_en),
            .x_i     (lane_x[gi]),
            .code_o  (lane_code[gi]),
            .clip_o  (lane_clip[gi])
        );
    end

    assign x0        = lane_code[0];
    assign x1        = lane_code[1];
    assign x2        = lane_code[2];
    assign x3        = lane_code[3];
    assign x4        = lane_code[4];
    assign x5        = lane_code[5];
    assign x6        = lane_code[6];
    assign x7        = lane_code[7];
    assign clip      = lane_clip;
    assign out_valid = s2_vld_q;

`ifdef DN_PWL_CLIP_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // one count per clipped beat, regardless of how many lanes clipped
    always_comb begin
        cnt_d = cnt_q;
        if (clip_clr)
            cnt_d = '0;
        else if (out_valid && out_ready && (|clip) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge arstb) begin
        if (!arstb)
            cnt_q <= '0;
        else if (!rstb)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign clip_cnt = cnt_q;
`else
    logic unused_clip_clr;
    assign unused_clip_clr = clip_clr;
    assign clip_cnt        = '0;
`endif

endmodule
